// File: rtl/cpu_csr_unit_if.sv
// CSR access, trap-strobe and trap-status bundle between the pipeline/trap controller and cpu_csr_unit.
interface cpu_csr_unit_if #(
    parameter int XLEN = 32
);
    logic [11:0]     raddr;
    logic [XLEN-1:0] rdata;
    logic            rillegal;
    logic [11:0]     waddr;
    logic [XLEN-1:0] wdata;
    logic [1:0]      wop;
    logic            wenable;
    logic            trap_valid;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_tval;
    logic            mret;
    logic            instret;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] epc;
    logic            mie;

    modport master (
        output raddr, waddr, wdata, wop, wenable, trap_valid, trap_pc,
               trap_cause, trap_tval, mret, instret,
        input  rdata, rillegal, trap_target, epc, mie
    );

    modport slave (
        input  raddr, waddr, wdata, wop, wenable, trap_valid, trap_pc,
               trap_cause, trap_tval, mret, instret,
        output rdata, rillegal, trap_target, epc, mie
    );
endinterface

// File: rtl/cpu_csr_unit.sv
// Machine-mode CSR unit: trap state, CSR read-modify-write, trap entry and mret.
// Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters.
module cpu_csr_unit #(
    parameter int          XLEN        = 32,
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter int          HART_ID     = 0,
    parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
    input  logic             clk,
    input  logic             rst,
    cpu_csr_unit_if.slave    bus
);
    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    function automatic logic [XLEN-1:0] apply_op(input logic [1:0] op,
                                                 input logic [XLEN-1:0] old,
                                                 input logic [XLEN-1:0] d);
        case (op)
            2'd1:    return d;
            2'd2:    return old | d;
            2'd3:    return old & ~d;
            default: return old;
        endcase
    endfunction

    logic            mie_reg, mie_next;
    logic            mpie_reg, mpie_next;
    logic [XLEN-1:0] mtvec_reg, mtvec_next;
    logic [XLEN-1:0] mscratch_reg, mscratch_next;
    logic [XLEN-1:0] mepc_reg, mepc_next;
    logic [XLEN-1:0] mcause_reg, mcause_next;
    logic [XLEN-1:0] mtval_reg, mtval_next;
    logic [XLEN-1:0] mstatus_val;
    logic [XLEN-1:0] wval;
    logic            write_en;

    // MPP is hardwired to machine mode; only MIE and MPIE are real state.
    assign mstatus_val = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpie_reg, 3'b000, mie_reg, 3'b000};
    assign write_en    = bus.wenable && (bus.wop != 2'b00);

    always_comb begin
        mie_next      = mie_reg;
        mpie_next     = mpie_reg;
        mtvec_next    = mtvec_reg;
        mscratch_next = mscratch_reg;
        mepc_next     = mepc_reg;
        mcause_next   = mcause_reg;
        mtval_next    = mtval_reg;
        wval          = '0;
        if (write_en) begin
            case (bus.waddr)
                ADDR_MSTATUS: if (!bus.trap_valid && !bus.mret) begin
                    wval      = apply_op(bus.wop, mstatus_val, bus.wdata);
                    mie_next  = wval[3];
                    mpie_next = wval[7];
                end
                ADDR_MTVEC: begin
                    wval       = apply_op(bus.wop, mtvec_reg, bus.wdata);
                    mtvec_next = {wval[XLEN-1:2], 1'b0, (wval[1:0] == 2'b01)};
                end
                ADDR_MSCRATCH: mscratch_next = apply_op(bus.wop, mscratch_reg, bus.wdata);
                ADDR_MEPC: if (!bus.trap_valid) begin
                    wval      = apply_op(bus.wop, mepc_reg, bus.wdata);
                    mepc_next = {wval[XLEN-1:2], 2'b00};
                end
                ADDR_MCAUSE: if (!bus.trap_valid) mcause_next = apply_op(bus.wop, mcause_reg, bus.wdata);
                ADDR_MTVAL:  if (!bus.trap_valid) mtval_next  = apply_op(bus.wop, mtval_reg, bus.wdata);
                default: ;
            endcase
        end
        if (bus.trap_valid) begin
            mepc_next   = bus.trap_pc & ~XLEN'(3);
            mcause_next = bus.trap_cause;
            mtval_next  = bus.trap_tval;
            mpie_next   = mie_reg;
            mie_next    = 1'b0;
        end else if (bus.mret) begin
            mie_next  = mpie_reg;
            mpie_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_reg      <= 1'b0;
            mpie_reg     <= 1'b0;
            mtvec_reg    <= MTVEC_RESET;
            mscratch_reg <= '0;
            mepc_reg     <= '0;
            mcause_reg   <= '0;
            mtval_reg    <= '0;
        end else begin
            mie_reg      <= mie_next;
            mpie_reg     <= mpie_next;
            mtvec_reg    <= mtvec_next;
            mscratch_reg <= mscratch_next;
            mepc_reg     <= mepc_next;
            mcause_reg   <= mcause_next;
            mtval_reg    <= mtval_next;
        end
    end

`ifdef CSR_COUNTERS_EN
    // Index 0 is mcycle (0xB00/0xB80), index 1 is minstret (0xB02/0xB82).
    logic [63:0] cnt_val [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        localparam logic [11:0] LO_ADDR = 12'hB00 + 12'(2 * gi);
        localparam logic [11:0] HI_ADDR = 12'hB80 + 12'(2 * gi);
        logic [63:0] cnt_reg, cnt_next;
        logic        inc;

        if (gi == 0) begin : g_cyc
            assign inc = 1'b1;
        end else begin : g_ret
            assign inc = bus.instret;
        end

        // A write to either half replaces that cycle's increment entirely.
        always_comb begin
            cnt_next = cnt_reg + 64'(inc);
            if (write_en && bus.waddr == LO_ADDR)
                cnt_next = {cnt_reg[63:32], apply_op(bus.wop, cnt_reg[31:0], bus.wdata)};
            else if (write_en && bus.waddr == HI_ADDR)
                cnt_next = {apply_op(bus.wop, cnt_reg[63:32], bus.wdata), cnt_reg[31:0]};
        end

        always_ff @(posedge clk) begin
            if (rst) cnt_reg <= '0;
            else     cnt_reg <= cnt_next;
        end

        assign cnt_val[gi] = cnt_reg;
    end
`else
    logic unused_instret;
    assign unused_instret = bus.instret;
`endif

    always_comb begin
        bus.rdata    = '0;
        bus.rillegal = 1'b0;
        case (bus.raddr)
            ADDR_MSTATUS:  bus.rdata = mstatus_val;
            ADDR_MISA:     bus.rdata = MISA_VAL;
            ADDR_MTVEC:    bus.rdata = mtvec_reg;
            ADDR_MSCRATCH: bus.rdata = mscratch_reg;
            ADDR_MEPC:     bus.rdata = mepc_reg;
            ADDR_MCAUSE:   bus.rdata = mcause_reg;
            ADDR_MTVAL:    bus.rdata = mtval_reg;
            ADDR_MHARTID:  bus.rdata = XLEN'(HART_ID);
`ifdef CSR_COUNTERS_EN
            12'hB00:       bus.rdata = cnt_val[0][31:0];
            12'hB80:       bus.rdata = cnt_val[0][63:32];
            12'hB02:       bus.rdata = cnt_val[1][31:0];
            12'hB82:       bus.rdata = cnt_val[1][63:32];
`endif
            default:       bus.rillegal = 1'b1;
        endcase
    end

    logic [XLEN-1:0] trap_base;
    assign trap_base = {mtvec_reg[XLEN-1:2], 2'b00};

    // Only interrupts are vectored; exceptions always land on the base.
    assign bus.trap_target = (mtvec_reg[0] && bus.trap_cause[XLEN-1])
                           ? trap_base + {bus.trap_cause[XLEN-3:0], 2'b00}
                           : trap_base;
    assign bus.epc = mepc_reg;
    assign bus.mie = mie_reg;
endmodule

// File: tb/tb_cpu_csr_unit.sv
// Directed plus randomized bench for cpu_csr_unit against an architectural CSR model.
module tb_cpu_csr_unit;
    localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
    localparam int          HART      = 3;
    localparam logic [31:0] MISA      = 32'h4000_0100;
`ifdef CSR_COUNTERS_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    cpu_csr_unit_if #(.XLEN(32)) bus ();

    cpu_csr_unit #(
        .XLEN(32), .MTVEC_RESET(MTVEC_RST), .HART_ID(HART), .MISA_VAL(MISA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Architectural model state
    bit          m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cycle, m_instret;

    logic [11:0] addr_list [15] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                    12'h343, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14,
                                    12'h7C0, 12'h344, 12'hC00};

    function automatic logic [32:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b0, 32'h1800 | (m_mpie ? 32'h80 : 32'h0) | (m_mie ? 32'h8 : 32'h0)};
            12'h301: return {1'b0, MISA};
            12'h305: return {1'b0, m_mtvec};
            12'h340: return {1'b0, m_mscratch};
            12'h341: return {1'b0, m_mepc};
            12'h342: return {1'b0, m_mcause};
            12'h343: return {1'b0, m_mtval};
            12'hF14: return {1'b0, 32'(HART)};
            12'hB00: return HAS_CNT ? {1'b0, m_cycle[31:0]}    : {1'b1, 32'h0};
            12'hB80: return HAS_CNT ? {1'b0, m_cycle[63:32]}   : {1'b1, 32'h0};
            12'hB02: return HAS_CNT ? {1'b0, m_instret[31:0]}  : {1'b1, 32'h0};
            12'hB82: return HAS_CNT ? {1'b0, m_instret[63:32]} : {1'b1, 32'h0};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] cause);
        logic [31:0] base;
        base = m_mtvec & 32'hFFFF_FFFC;
        if ((m_mtvec & 32'h3) == 32'h1 && cause >= 32'h8000_0000)
            return base + (cause - 32'h8000_0000) * 32'd4;
        return base;
    endfunction

    // Next architectural state from the inputs currently driven.
    task automatic model_edge();
        logic [32:0] r;
        logic [31:0] old, nv;
        logic [63:0] nc, ni;
        bit n_mie, n_mpie;
        logic [31:0] n_mtvec, n_mscratch, n_mepc, n_mcause, n_mtval;
        if (rst) begin
            m_mie = 0; m_mpie = 0; m_mtvec = MTVEC_RST; m_mscratch = 0;
            m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cycle = 0; m_instret = 0;
            return;
        end
        nc = m_cycle + 64'd1;
        ni = m_instret + (bus.instret ? 64'd1 : 64'd0);
        n_mie = m_mie; n_mpie = m_mpie; n_mtvec = m_mtvec; n_mscratch = m_mscratch;
        n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
        r   = model_read(bus.waddr);
        old = r[31:0];
        nv  = (bus.wop == 2'd1) ? bus.wdata : (bus.wop == 2'd2) ? (old | bus.wdata) : (old & ~bus.wdata);
        if (bus.wenable && bus.wop != 2'd0) begin
            case (bus.waddr)
                12'h300: if (!bus.trap_valid && !bus.mret) begin n_mie = nv[3]; n_mpie = nv[7]; end
                12'h305: n_mtvec = ((nv & 32'h3) == 32'h1) ? nv : (nv & 32'hFFFF_FFFC);
                12'h340: n_mscratch = nv;
                12'h341: if (!bus.trap_valid) n_mepc = nv & 32'hFFFF_FFFC;
                12'h342: if (!bus.trap_valid) n_mcause = nv;
                12'h343: if (!bus.trap_valid) n_mtval = nv;
                12'hB00: if (HAS_CNT) nc = {m_cycle[63:32], nv};
                12'hB80: if (HAS_CNT) nc = {nv, m_cycle[31:0]};
                12'hB02: if (HAS_CNT) ni = {m_instret[63:32], nv};
                12'hB82: if (HAS_CNT) ni = {nv, m_instret[31:0]};
                default: ;
            endcase
        end
        if (bus.trap_valid) begin
            n_mepc = bus.trap_pc & 32'hFFFF_FFFC;
            n_mcause = bus.trap_cause;
            n_mtval = bus.trap_tval;
            n_mpie = m_mie;
            n_mie = 0;
        end else if (bus.mret) begin
            n_mie = m_mpie;
            n_mpie = 1;
        end
        m_mie = n_mie; m_mpie = n_mpie; m_mtvec = n_mtvec; m_mscratch = n_mscratch;
        m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval; m_cycle = nc; m_instret = ni;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [11:0] a, input logic [31:0] exp_d, input bit exp_ill);
        bus.raddr = a;
        #1;
        chk({tag, "_data"}, bus.rdata, exp_d);
        chk({tag, "_ill"}, {31'b0, bus.rillegal}, {31'b0, exp_ill});
    endtask

    task automatic chk_model_rd(input string tag, input logic [11:0] a);
        logic [32:0] r;
        r = model_read(a);
        chk_rd(tag, a, r[31:0], r[32]);
    endtask

    task automatic csr_op(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.wenable = 1'b1; bus.wop = op; bus.waddr = a; bus.wdata = d;
        step();
        bus.wenable = 1'b0; bus.wop = 2'd0;
    endtask

    initial begin
        rst = 1'b1;
        bus.raddr = 0; bus.waddr = 0; bus.wdata = 0; bus.wop = 0; bus.wenable = 0;
        bus.trap_valid = 0; bus.trap_pc = 0; bus.trap_cause = 0; bus.trap_tval = 0;
        bus.mret = 0; bus.instret = 0;
        step();
        step();
        chk_rd("rst_mtvec", 12'h305, MTVEC_RST, 1'b0);
        chk_rd("rst_mstatus", 12'h300, 32'h0000_1800, 1'b0);
        chk_rd("rst_unimpl", 12'h7C0, 32'h0, 1'b1);
        chk("rst_epc", bus.epc, 32'h0);
        chk("rst_mie", {31'b0, bus.mie}, 32'h0);
        rst = 1'b0;

        csr_op(2'd1, 12'h305, 32'h8000_0003);
        chk_rd("mtvec_mode3", 12'h305, 32'h8000_0000, 1'b0);
        csr_op(2'd1, 12'h305, 32'h8000_0001);
        chk_rd("mtvec_vec", 12'h305, 32'h8000_0001, 1'b0);
        bus.trap_cause = 32'h8000_0007; #1;
        chk("tgt_irq", bus.trap_target, 32'h8000_001C);
        bus.trap_cause = 32'h2; #1;
        chk("tgt_exc", bus.trap_target, 32'h8000_0000);

        csr_op(2'd2, 12'h300, 32'h8);
        chk("mie_set", {31'b0, bus.mie}, 32'h1);
        bus.trap_valid = 1; bus.trap_pc = 32'h1236; bus.trap_cause = 32'h2; bus.trap_tval = 32'hDEAD;
        step();
        bus.trap_valid = 0;
        chk("trap_epc", bus.epc, 32'h1234);
        chk_rd("trap_mstatus", 12'h300, 32'h1880, 1'b0);
        chk("trap_mie", {31'b0, bus.mie}, 32'h0);
        chk_rd("trap_mcause", 12'h342, 32'h2, 1'b0);
        chk_rd("trap_mtval", 12'h343, 32'hDEAD, 1'b0);
        bus.mret = 1;
        step();
        bus.mret = 0;
        chk_rd("mret_mstatus", 12'h300, 32'h1888, 1'b0);
        chk("mret_mie", {31'b0, bus.mie}, 32'h1);

        bus.trap_valid = 1; bus.trap_pc = 32'h2003;
        csr_op(2'd1, 12'h341, 32'hABC);
        bus.trap_valid = 0;
        chk("trap_vs_wr_epc", bus.epc, 32'h2000);
        bus.mret = 1;
        csr_op(2'd1, 12'h340, 32'h5);
        bus.mret = 0;
        chk_rd("mret_wr_mscratch", 12'h340, 32'h5, 1'b0);
        bus.mret = 1;
        csr_op(2'd3, 12'h300, 32'h8);
        bus.mret = 0;
        chk_rd("mret_vs_wr_mstatus", 12'h300, 32'h1888, 1'b0);
        csr_op(2'd3, 12'h300, 32'h8);
        chk("clr_mie", {31'b0, bus.mie}, 32'h0);
        chk_rd("clr_mstatus", 12'h300, 32'h1880, 1'b0);
        csr_op(2'd0, 12'h300, 32'h88);
        chk_rd("wop0_mstatus", 12'h300, 32'h1880, 1'b0);
        csr_op(2'd1, 12'h341, 32'h1237);
        chk("mepc_align", bus.epc, 32'h1234);
        csr_op(2'd1, 12'h301, 32'h0);
        chk_rd("misa_ro", 12'h301, MISA, 1'b0);
        chk_rd("mhartid", 12'hF14, 32'(HART), 1'b0);
        csr_op(2'd1, 12'h7C0, 32'h5);
        chk_rd("unimpl_wr", 12'h7C0, 32'h0, 1'b1);

`ifdef CSR_COUNTERS_EN
        csr_op(2'd1, 12'hB00, 32'hFFFF_FFFF);
        csr_op(2'd1, 12'hB80, 32'h0);
        chk_rd("mcycleh_wr", 12'hB80, 32'h0, 1'b0);
        chk_rd("mcycle_hold", 12'hB00, 32'hFFFF_FFFF, 1'b0);
        step();
        chk_rd("mcycleh_carry", 12'hB80, 32'h1, 1'b0);
        chk_rd("mcycle_wrap", 12'hB00, 32'h0, 1'b0);
        bus.instret = 1;
        csr_op(2'd1, 12'hB82, 32'h7);
        chk_rd("minstreth_wr", 12'hB82, 32'h7, 1'b0);
        chk_rd("minstret_hold", 12'hB02, 32'h0, 1'b0);
        step();
        bus.instret = 0;
        chk_rd("minstret_inc", 12'hB02, 32'h1, 1'b0);
`else
        csr_op(2'd1, 12'hB00, 32'h5);
        chk_rd("nocnt_mcycle", 12'hB00, 32'h0, 1'b1);
        chk_rd("nocnt_minstreth", 12'hB82, 32'h0, 1'b1);
`endif

        for (int i = 0; i < 300; i++) begin
            rst            = ($urandom_range(0, 99) == 0);
            bus.wenable    = $urandom_range(0, 1);
            bus.wop        = 2'($urandom_range(0, 3));
            bus.waddr      = addr_list[$urandom_range(0, 14)];
            bus.wdata      = $urandom;
            bus.trap_valid = ($urandom_range(0, 7) == 0);
            bus.mret       = ($urandom_range(0, 7) == 0);
            bus.instret    = $urandom_range(0, 1);
            bus.trap_pc    = $urandom;
            bus.trap_cause = {1'($urandom_range(0, 1)), 31'($urandom_range(0, 40))};
            bus.trap_tval  = $urandom;
            #1;
            chk("rnd_target", bus.trap_target, model_target(bus.trap_cause));
            step();
            chk("rnd_epc", bus.epc, m_mepc);
            chk("rnd_mie", {31'b0, bus.mie}, {31'b0, m_mie});
            chk_model_rd("rnd_read", addr_list[$urandom_range(0, 14)]);
        end
        rst = 0; bus.trap_valid = 0; bus.mret = 0; bus.wenable = 0;
        step();

        csr_op(2'd2, 12'h300, 32'h8);
        rst = 1; bus.trap_valid = 1; bus.trap_pc = 32'h4444;
        csr_op(2'd1, 12'h340, 32'h9);
        rst = 0; bus.trap_valid = 0;
        chk_rd("rst_mid_mscratch", 12'h340, 32'h0, 1'b0);
        chk_rd("rst_mid_mtvec", 12'h305, MTVEC_RST, 1'b0);
        chk_rd("rst_mid_mstatus", 12'h300, 32'h1800, 1'b0);
        chk("rst_mid_epc", bus.epc, 32'h0);
        chk_model_rd("rst_mid_mcycle", 12'hB00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
